// File: rtl/dot_matrix_row_scanner_pkg.sv
// Shared geometry for the 7x5 dot-matrix display path (scanner and pattern mux).
// Latency: n/a (constants and a pure index helper).
// Backpressure: n/a.
package dot_matrix_pkg;

  localparam int ROWS    = 7;
  localparam int COLS    = 5;
  localparam int FRAME_W = ROWS * COLS;

  // Flat frame bit index of pixel (row r, column c).
  function automatic int pix_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/dot_matrix_row_scanner_if.sv
// Frame-in / drive-out bundle between the pattern source and the row scanner.
// Latency: n/a (wires only).
// Backpressure: none; the frame is a static level sampled once per scan.
interface dot_matrix_row_scanner_if;
  import dot_matrix_pkg::*;

  logic               en;
  logic [FRAME_W-1:0] frame;
  logic [ROWS-1:0]    row;
  logic [COLS-1:0]    col_n;
  logic               frame_sync;

  modport master (output en, output frame, input row, input col_n, input frame_sync);
  modport slave  (input en, input frame, output row, output col_n, output frame_sync);

endinterface

// File: rtl/dot_matrix_row_scanner_slot_timer.sv
// Slot/row counters for the scanner; flags the frame-start slot and the lit part of each slot.
// Latency: strobes are combinational from the current counter state.
// Backpressure: none; en low or rst holds the counters at row 0, slot start.
module slot_timer
  import dot_matrix_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16,
  localparam int CW   = $clog2(DIV),
  localparam int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [RW-1:0] row,
  output logic          frame_start,
  output logic          lit
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  // Frame starts on the very first cycle of row 0; the slot is lit once blanking is over.
  assign frame_start = en && (cnt == '0) && (row == '0);
  assign lit         = (cnt >= CNT_LIT);

  // Advance the slot counter every enabled cycle and step the row at the slot end.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      row <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      row <= (row == ROW_LAST) ? '0 : row + RW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dot_matrix_row_scanner.sv
// Time-multiplexed 7x5 LED driver: one-hot row anodes, active-low column sinks, shadowed frame.
// Latency: outputs are registered and reflect the previous cycle's slot/row; frame_sync 1 cycle after latch.
// Backpressure: none; en low darkens the display on the next edge and restarts the scan at row 0.
module dot_matrix_row_scanner
  import dot_matrix_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  dot_matrix_row_scanner_if.slave  bus
);

  localparam int CW = $clog2(DIV);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0]      cnt;
  logic [RW-1:0]      row_idx;
  logic               frame_start;
  logic               lit;
  logic [FRAME_W-1:0] shadow;
  logic [ROWS-1:0]    row_q;
  logic [COLS-1:0]    col_n_q;
  logic               frame_sync_q;

  slot_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_slot_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .cnt         (cnt),
    .row         (row_idx),
    .frame_start (frame_start),
    .lit         (lit)
  );

  // The counter value itself is only needed inside the timer; strobes carry what we use.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

  // Shadow the frame once per scan and drive the registered row/column outputs.
  // The latch cycle is always blanked (cnt 0 < BLANK), so the first lit cycle already sees the new shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      row_q        <= '0;
      col_n_q      <= '1;
      frame_sync_q <= 1'b0;
    end else if (!bus.en) begin
      row_q        <= '0;
      col_n_q      <= '1;
      frame_sync_q <= 1'b0;
    end else begin
      frame_sync_q <= frame_start;
      if (frame_start) begin
        shadow <= bus.frame;
      end
      if (lit) begin
        row_q   <= ROWS'(1) << row_idx;
        col_n_q <= ~shadow[pix_idx(int'(row_idx), 0) +: COLS];
      end else begin
        row_q   <= '0;
        col_n_q <= '1;
      end
    end
  end

  assign bus.row        = row_q;
  assign bus.col_n      = col_n_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_dot_matrix_row_scanner.sv
// Directed bench for the row scanner at DIV=8, BLANK=2.
// Index k counts edges after reset release with en=1; edge k saw cnt=k%8, row=(k/8)%7.
// Backpressure: n/a.
module tb_dot_matrix_row_scanner;
  import dot_matrix_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dot_matrix_row_scanner_if dmif ();

  dot_matrix_row_scanner #(.DIV(8), .BLANK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dmif)
  );

  always #5 clk = ~clk;

  // Row drive is one-hot-or-zero and never jumps directly between two lit rows.
  assert property (@(posedge clk) $onehot0(dmif.row))
    else begin errors++; $display("FAIL onehot0 row=%h", dmif.row); end
  assert property (@(posedge clk) (dmif.row != '0) |-> ($past(dmif.row) == '0 || $past(dmif.row) == dmif.row))
    else begin errors++; $display("FAIL row_step row=%h prev=%h", dmif.row, $past(dmif.row)); end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected row drive after edge k, straight from the slot timing rules.
  function automatic logic [6:0] exp_row(input int k);
    int c;
    int r;
    c = k % 8;
    r = (k / 8) % 7;
    return (c >= 2) ? 7'(1 << r) : 7'h00;
  endfunction

  // Hold reset two cycles with en=1 and the given frame; next edge is k=0.
  task automatic start_scan(input logic [34:0] f);
    rst = 1'b1;
    dmif.en = 1'b1;
    dmif.frame = f;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmif.en = 1'b1;
    dmif.frame = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dmif.row !== 7'h00 || dmif.col_n !== 5'h1F || dmif.frame_sync !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d row=%h col_n=%h fs=%b want 00/1f/0", i, dmif.row, dmif.col_n, dmif.frame_sync);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dmif.frame_sync !== 1'b1 || dmif.row !== 7'h00) begin
      errors++;
      $display("FAIL reset_release fs=%b row=%h want 1/00", dmif.frame_sync, dmif.row);
    end
  endtask

  task automatic test_scan();
    logic [6:0] er;
    start_scan(35'h7_FFFF_FFFF);
    for (int k = 0; k < 120; k++) begin
      tick();
      er = exp_row(k);
      checks++;
      if (dmif.row !== er || dmif.col_n !== ((er != 0) ? 5'h00 : 5'h1F) || dmif.frame_sync !== (k % 56 == 0)) begin
        errors++;
        $display("FAIL scan k=%0d row=%h col_n=%h fs=%b want row=%h", k, dmif.row, dmif.col_n, dmif.frame_sync, er);
      end
    end
  endtask

  task automatic test_single_pixel();
    logic [34:0] f;
    logic [6:0]  er;
    logic [4:0]  ec;
    f = '0;
    f[pix_idx(2, 3)] = 1'b1;
    start_scan(f);
    for (int k = 0; k < 60; k++) begin
      tick();
      er = exp_row(k);
      ec = (er == 7'h04) ? 5'b10111 : 5'h1F;
      checks++;
      if (dmif.row !== er || dmif.col_n !== ec) begin
        errors++;
        $display("FAIL pixel k=%0d row=%h col_n=%b want %h/%b", k, dmif.row, dmif.col_n, er, ec);
      end
    end
  endtask

  task automatic test_no_tear();
    logic [6:0] er;
    logic [4:0] ec;
    start_scan(35'h7_FFFF_FFFF);
    for (int k = 0; k < 112; k++) begin
      tick();
      if (k == 26) dmif.frame = '0;
      er = exp_row(k);
      ec = (er != 0 && k < 56) ? 5'h00 : 5'h1F;
      checks++;
      if (dmif.row !== er || dmif.col_n !== ec) begin
        errors++;
        $display("FAIL no_tear k=%0d row=%h col_n=%h want %h/%h", k, dmif.row, dmif.col_n, er, ec);
      end
    end
  endtask

  task automatic test_en_drop();
    start_scan(35'h7_FFFF_FFFF);
    for (int k = 0; k <= 36; k++) tick();
    checks++;
    if (dmif.row !== 7'h10 || dmif.col_n !== 5'h00) begin
      errors++;
      $display("FAIL en_pre row=%h col_n=%h want 10/00", dmif.row, dmif.col_n);
    end
    dmif.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dmif.row !== 7'h00 || dmif.col_n !== 5'h1F || dmif.frame_sync !== 1'b0) begin
        errors++;
        $display("FAIL en_dark i=%0d row=%h col_n=%h fs=%b", i, dmif.row, dmif.col_n, dmif.frame_sync);
      end
    end
    dmif.en = 1'b1;
    tick();
    checks++;
    if (dmif.frame_sync !== 1'b1 || dmif.row !== 7'h00) begin
      errors++;
      $display("FAIL en_resync fs=%b row=%h want 1/00", dmif.frame_sync, dmif.row);
    end
    tick();
    checks++;
    if (dmif.frame_sync !== 1'b0 || dmif.row !== 7'h00) begin
      errors++;
      $display("FAIL en_blank fs=%b row=%h want 0/00", dmif.frame_sync, dmif.row);
    end
    tick();
    checks++;
    if (dmif.row !== 7'h01 || dmif.col_n !== 5'h00) begin
      errors++;
      $display("FAIL en_relit row=%h col_n=%h want 01/00", dmif.row, dmif.col_n);
    end
  endtask

  task automatic test_rst_mid();
    start_scan(35'h7_FFFF_FFFF);
    for (int k = 0; k <= 44; k++) tick();
    checks++;
    if (dmif.row !== 7'h20) begin
      errors++;
      $display("FAIL rst_pre row=%h want 20", dmif.row);
    end
    rst = 1'b1;
    dmif.frame = 35'h1;
    tick();
    checks++;
    if (dmif.row !== 7'h00 || dmif.col_n !== 5'h1F || dmif.frame_sync !== 1'b0 || dut.shadow !== 35'h0) begin
      errors++;
      $display("FAIL rst_dark row=%h col_n=%h fs=%b shadow=%h", dmif.row, dmif.col_n, dmif.frame_sync, dut.shadow);
    end
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (dmif.frame_sync !== 1'b1) begin
          errors++;
          $display("FAIL rst_resync fs=%b want 1", dmif.frame_sync);
        end
      end
      if (k == 2) begin
        checks++;
        if (dmif.row !== 7'h01 || dmif.col_n !== 5'b11110) begin
          errors++;
          $display("FAIL rst_row0 row=%h col_n=%b want 01/11110", dmif.row, dmif.col_n);
        end
      end
      if (k == 10) begin
        checks++;
        if (dmif.row !== 7'h02 || dmif.col_n !== 5'h1F) begin
          errors++;
          $display("FAIL rst_row1 row=%h col_n=%h want 02/1f", dmif.row, dmif.col_n);
        end
      end
    end
  endtask

  initial begin
    dmif.en = 1'b1;
    dmif.frame = '1;
    test_reset();
    test_scan();
    test_single_pixel();
    test_no_tear();
    test_en_drop();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
